// File: rtl/lmt01_pkg.sv
// Shared definitions for the LMT01 pulse-count transmitter.
//   - FSM state encoding
//   - default timing (128 MHz clock: 800/800-cycle pulses, 100 ms frame)
//   - count limit and temperature-to-count conversion constants/helper
package lmt01_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } lmt01_state_e;

    localparam int unsigned DEF_CNT_W     = 12;
    localparam int unsigned DEF_PULSE_HI  = 800;
    localparam int unsigned DEF_PULSE_LO  = 800;
    localparam int unsigned DEF_FRAME_CYC = 12800000;

    localparam int unsigned CNT_MAX = (1 << DEF_CNT_W) - 1;

    localparam int unsigned TEMP_OFFSET = 50;
    localparam int unsigned TEMP_SCALE  = 16;

    // Unsaturated pulse count for temperature t; caller clamps to its width.
    function automatic int unsigned temp_to_count(input logic [7:0] t);
        return (32'(t) + TEMP_OFFSET) * TEMP_SCALE;
    endfunction

endpackage

// File: rtl/lmt01_pulse_gen_timer.sv
// lmt01_pulse_timer: loadable down-counter used to time HIGH and LOW phases.
// Ports:
//   clk          rising-edge clock
//   reset_count  synchronous active-low reset
//   load_i       load load_val_i this cycle
//   load_val_i   value loaded (phase length minus one)
//   done_o       counter has reached zero
module lmt01_pulse_timer
    import lmt01_pkg::*;
#(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         reset_count,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_count) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lmt01_pulse_gen.sv
// lmt01_pulse_gen: transmitter side of the LMT01 single-wire pulse-count
// protocol. Each frame emits a burst of N pulses on pulse_o, then holds the
// line low until FRAME_CYC cycles after the burst started.
// Build option: LMT01_TEMP_IN_EN -- cnt_i[7:0] is a temperature t and the
// stored count becomes min((t+50)*16, 2^CNT_W-1).
// Ports:
//   clk            rising-edge clock
//   reset_count    synchronous active-low reset
//   enable_i       run frames while high
//   cnt_i          requested pulse count (or temperature, see above)
//   cnt_valid_i    cnt_i valid
//   cnt_ready_o    pending slot empty
//   pulse_o        LMT01 line (registered)
//   frame_start_o  one-cycle strobe at frame begin
//   frame_done_o   one-cycle strobe on last frame cycle
//   busy_o         FSM not idle
module lmt01_pulse_gen
    import lmt01_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned PULSE_HI  = DEF_PULSE_HI,
    parameter int unsigned PULSE_LO  = DEF_PULSE_LO,
    parameter int unsigned FRAME_CYC = DEF_FRAME_CYC
) (
    input  logic             clk,
    input  logic             reset_count,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             cnt_valid_i,
    output logic             cnt_ready_o,
    output logic             pulse_o,
    output logic             frame_start_o,
    output logic             frame_done_o,
    output logic             busy_o
);

    localparam int unsigned TMR_MAX = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
    localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned FT_W    = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;

    localparam logic [TW-1:0]   HI_LOAD = TW'(PULSE_HI - 1);
    localparam logic [TW-1:0]   LO_LOAD = TW'(PULSE_LO - 1);
    localparam logic [FT_W-1:0] FT_LAST = FT_W'(FRAME_CYC - 1);

    lmt01_state_e     state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [FT_W-1:0]  ft_q, ft_d;
    logic             pulse_q, pulse_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             start_frame;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_done;
    logic [CNT_W-1:0] cnt_conv;

`ifdef LMT01_TEMP_IN_EN
    localparam int unsigned CNT_LIM = (1 << CNT_W) - 1;
    int unsigned temp_cnt;
    logic        unused_cnt_hi;

    assign unused_cnt_hi = ^cnt_i[CNT_W-1:8];

    always_comb begin
        temp_cnt = temp_to_count(cnt_i[7:0]);
        if (temp_cnt > CNT_LIM) begin
            cnt_conv = '1;
        end else begin
            cnt_conv = temp_cnt[CNT_W-1:0];
        end
    end
`else
    assign cnt_conv = cnt_i;
`endif

    lmt01_pulse_timer #(.W(TW)) u_timer (
        .clk         (clk),
        .reset_count (reset_count),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .done_o      (tmr_done)
    );

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        pc_d          = pc_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        frame_done_d  = 1'b0;
        frame_start_d = 1'b0;
        start_frame   = 1'b0;
        accept        = cnt_valid_i && !pend_full_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    start_frame = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d  = ST_LOW;
                    pc_d     = pc_q + CNT_W'(1);
                    tmr_load = 1'b1;
                    tmr_val  = LO_LOAD;
                end
            end
            ST_LOW: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    if (pc_q == act_q) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d  = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = HI_LOAD;
                    end
                end
            end
            ST_GAP: begin
                // A completed frame reports done even if enable falls on
                // its last cycle; only earlier drops are silent aborts.
                if (ft_q == FT_LAST) begin
                    frame_done_d = 1'b1;
                    if (enable_i) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pending value (if any) becomes the active count; otherwise the
        // previous count repeats.
        if (start_frame) begin
            frame_start_d = 1'b1;
            pc_d          = '0;
            act_d         = pend_full_q ? pend_q : act_q;
            if (act_d == '0) begin
                state_d = ST_GAP;
            end else begin
                state_d  = ST_HIGH;
                tmr_load = 1'b1;
                tmr_val  = HI_LOAD;
            end
        end

        pend_full_d = accept || (pend_full_q && !start_frame);
        pend_d      = accept ? cnt_conv : pend_q;

        if (start_frame) begin
            ft_d = '0;
        end else if (state_q != ST_IDLE && ft_q != FT_LAST) begin
            ft_d = ft_q + FT_W'(1);
        end else begin
            ft_d = ft_q;
        end

        // The line trails the state by one cycle, so the first rise lands
        // the cycle after the frame_start_o strobe.
        pulse_d = (state_q == ST_HIGH) && enable_i;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_count) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            act_q         <= '0;
            pc_q          <= '0;
            ft_q          <= '0;
            pulse_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            act_q         <= act_d;
            pc_q          <= pc_d;
            ft_q          <= ft_d;
            pulse_q       <= pulse_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign cnt_ready_o   = !pend_full_q;
    assign pulse_o       = pulse_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_lmt01_pulse_gen.sv
// Self-checking bench for lmt01_pulse_gen with PULSE_HI=4, PULSE_LO=4,
// FRAME_CYC=200. A negedge monitor turns the line into per-frame records;
// each test pushes expected counts and compares against popped records.
module tb_lmt01_pulse_gen;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned PHI   = 4;
    localparam int unsigned PLO   = 4;
    localparam int unsigned FC    = 200;

    logic             clk = 1'b0;
    logic             reset_count = 1'b0;
    logic             enable_i = 1'b0;
    logic [CNT_W-1:0] cnt_i = '0;
    logic             cnt_valid_i = 1'b0;
    logic             cnt_ready_o;
    logic             pulse_o;
    logic             frame_start_o;
    logic             frame_done_o;
    logic             busy_o;

    always #5 clk = ~clk;

    lmt01_pulse_gen #(
        .CNT_W     (CNT_W),
        .PULSE_HI  (PHI),
        .PULSE_LO  (PLO),
        .FRAME_CYC (FC)
    ) dut (
        .clk           (clk),
        .reset_count   (reset_count),
        .enable_i      (enable_i),
        .cnt_i         (cnt_i),
        .cnt_valid_i   (cnt_valid_i),
        .cnt_ready_o   (cnt_ready_o),
        .pulse_o       (pulse_o),
        .frame_start_o (frame_start_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        int unsigned n;
        int          first_rise;
        int unsigned start_cyc;
        int unsigned done_cyc;
        bit          bad;
    } frame_t;

    frame_t      obs_q[$];
    int unsigned exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    int unsigned cyc = 0;
    bit          m_open = 1'b0;
    logic        m_prev = 1'b0;
    int unsigned m_hi = 0;
    int unsigned m_lo = 0;
    frame_t      m_cur;

    // Line monitor: pulse count, first-rise offset, width errors, frame span.
    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_count) begin
                m_open = 1'b0;
                m_prev = 1'b0;
            end else begin
                if (frame_done_o && m_open) begin
                    m_cur.done_cyc = cyc;
                    obs_q.push_back(m_cur);
                    m_open = 1'b0;
                end
                if (frame_start_o) begin
                    m_open = 1'b1;
                    m_cur = '{n: 0, first_rise: -1, start_cyc: cyc, done_cyc: 0, bad: 1'b0};
                    m_hi = 0;
                    m_lo = 0;
                end else if (m_open) begin
                    if (pulse_o) begin
                        if (!m_prev) begin
                            m_cur.n++;
                            if (m_cur.first_rise < 0) m_cur.first_rise = int'(cyc - m_cur.start_cyc);
                            else if (m_lo != PLO) m_cur.bad = 1'b1;
                            m_hi = 1;
                        end else begin
                            m_hi++;
                        end
                    end else begin
                        if (m_prev) begin
                            if (m_hi != PHI) m_cur.bad = 1'b1;
                            m_lo = 1;
                        end else begin
                            m_lo++;
                        end
                    end
                end
                m_prev = pulse_o;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [CNT_W-1:0] v, output bit ok);
        int unsigned k = 0;
        cnt_i = v;
        cnt_valid_i = 1'b1;
        while (!cnt_ready_o && k < 1000) begin
            step();
            k++;
        end
        ok = cnt_ready_o;
        step();
        cnt_valid_i = 1'b0;
    endtask

    task automatic wait_frame(input int unsigned budget, output frame_t f, output bit ok);
        int unsigned k = 0;
        ok = 1'b0;
        f = '{n: 0, first_rise: -1, start_cyc: 0, done_cyc: 0, bad: 1'b1};
        while (obs_q.size() == 0 && k < budget) begin
            step();
            k++;
        end
        if (obs_q.size() != 0) begin
            f = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_count = 1'b0;
        repeat (3) step();
        n_checks++; if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", pulse_o); end
        n_checks++; if (frame_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start_o); end
        n_checks++; if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (cnt_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cnt_ready_o); end
        reset_count = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bit ok, ok1, ok2;
        frame_t f1, f2;
        int unsigned e;
        send(CNT_W'(5), ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_send: ready got 0 want 1"); end
        n_checks++; if (cnt_ready_o !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop: got %b want 0", cnt_ready_o); end
        exp_q.push_back(5);
        exp_q.push_back(5);
        enable_i = 1'b1;
        wait_frame(400, f1, ok1);
        wait_frame(400, f2, ok2);
        enable_i = 1'b0;
        step();
        n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL basic_timeout: got frames %0d%0d want 11", ok1, ok2); end
        e = exp_q.pop_front();
        n_checks++; if (f1.n !== e) begin n_fail++; $display("FAIL basic_count1: got %0d want %0d", f1.n, e); end
        n_checks++; if (f1.bad !== 1'b0) begin n_fail++; $display("FAIL basic_width1: got bad=%0d want 0", f1.bad); end
        n_checks++; if (f1.first_rise !== 1) begin n_fail++; $display("FAIL basic_first_rise: got %0d want 1", f1.first_rise); end
        n_checks++; if (f1.done_cyc - f1.start_cyc !== FC) begin n_fail++; $display("FAIL basic_frame_len: got %0d want %0d", f1.done_cyc - f1.start_cyc, FC); end
        e = exp_q.pop_front();
        n_checks++; if (f2.n !== e) begin n_fail++; $display("FAIL basic_count2: got %0d want %0d", f2.n, e); end
        n_checks++; if (f2.start_cyc !== f1.done_cyc) begin n_fail++; $display("FAIL basic_b2b: got start %0d want %0d", f2.start_cyc, f1.done_cyc); end
        n_checks++; if (cnt_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_ready_rise: got %b want 1", cnt_ready_o); end
    endtask

    task automatic test_zero();
        bit ok;
        frame_t f;
        int unsigned e;
        send(CNT_W'(0), ok);
        exp_q.push_back(0);
        enable_i = 1'b1;
        wait_frame(400, f, ok);
        enable_i = 1'b0;
        step();
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no frame want frame"); end
        e = exp_q.pop_front();
        n_checks++; if (f.n !== e) begin n_fail++; $display("FAIL zero_count: got %0d want %0d", f.n, e); end
        n_checks++; if (f.first_rise !== -1) begin n_fail++; $display("FAIL zero_rise: got %0d want -1", f.first_rise); end
        n_checks++; if (f.done_cyc - f.start_cyc !== FC) begin n_fail++; $display("FAIL zero_frame_len: got %0d want %0d", f.done_cyc - f.start_cyc, FC); end
    endtask

    task automatic test_pending_hold();
        bit ok, ok1, ok2;
        frame_t f1, f2;
        int unsigned e, hi_cnt, k;
        send(CNT_W'(3), ok);
        cnt_i = CNT_W'(7);
        cnt_valid_i = 1'b1;
        hi_cnt = 0;
        repeat (10) begin
            step();
            if (cnt_ready_o) hi_cnt++;
        end
        n_checks++; if (hi_cnt !== 0) begin n_fail++; $display("FAIL pend_ready_held: got %0d ready cycles want 0", hi_cnt); end
        exp_q.push_back(3);
        exp_q.push_back(7);
        enable_i = 1'b1;
        k = 0;
        step();
        while (!cnt_ready_o && k < 50) begin
            step();
            k++;
        end
        n_checks++; if (frame_start_o !== 1'b1) begin n_fail++; $display("FAIL pend_ready_at_start: frame_start got %b want 1", frame_start_o); end
        step();
        cnt_valid_i = 1'b0;
        n_checks++; if (cnt_ready_o !== 1'b0) begin n_fail++; $display("FAIL pend_second_accept: ready got %b want 0", cnt_ready_o); end
        wait_frame(400, f1, ok1);
        wait_frame(400, f2, ok2);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f1.n !== e) begin n_fail++; $display("FAIL pend_count1: got %0d want %0d", f1.n, e); end
        e = exp_q.pop_front();
        n_checks++; if (f2.n !== e) begin n_fail++; $display("FAIL pend_count2: got %0d want %0d", f2.n, e); end
        n_checks++; if (f2.bad !== 1'b0) begin n_fail++; $display("FAIL pend_width2: got bad=%0d want 0", f2.bad); end
    endtask

    task automatic test_overrun();
        bit ok, ok1, ok2;
        frame_t f1, f2;
        int unsigned e;
        send(CNT_W'(30), ok);
        exp_q.push_back(30);
        exp_q.push_back(30);
        enable_i = 1'b1;
        wait_frame(600, f1, ok1);
        wait_frame(600, f2, ok2);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f1.n !== e) begin n_fail++; $display("FAIL ovr_count1: got %0d want %0d", f1.n, e); end
        n_checks++; if (f1.bad !== 1'b0) begin n_fail++; $display("FAIL ovr_width: got bad=%0d want 0", f1.bad); end
        n_checks++; if (f1.done_cyc - f1.start_cyc !== 30 * (PHI + PLO) + 1) begin n_fail++; $display("FAIL ovr_done: got %0d want %0d", f1.done_cyc - f1.start_cyc, 30 * (PHI + PLO) + 1); end
        e = exp_q.pop_front();
        n_checks++; if (f2.n !== e) begin n_fail++; $display("FAIL ovr_count2: got %0d want %0d", f2.n, e); end
        n_checks++; if (f2.start_cyc !== f1.done_cyc) begin n_fail++; $display("FAIL ovr_b2b: got start %0d want %0d", f2.start_cyc, f1.done_cyc); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        frame_t f;
        int unsigned e, rises, k, dones;
        logic prev;
        send(CNT_W'(5), ok);
        enable_i = 1'b1;
        prev = 1'b0;
        rises = 0;
        k = 0;
        while (rises < 2 && k < 100) begin
            step();
            k++;
            if (pulse_o && !prev) rises++;
            prev = pulse_o;
        end
        n_checks++; if (rises !== 2) begin n_fail++; $display("FAIL drop_reach_p2: got %0d rises want 2", rises); end
        enable_i = 1'b0;
        step();
        n_checks++; if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL drop_pulse: got %b want 0", pulse_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b want 0", busy_o); end
        dones = 0;
        repeat (300) begin
            step();
            if (frame_done_o) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL drop_no_done: got %0d strobes want 0", dones); end
        exp_q.push_back(5);
        enable_i = 1'b1;
        wait_frame(400, f, ok);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f.n !== e) begin n_fail++; $display("FAIL drop_refresh_count: got %0d want %0d", f.n, e); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        frame_t f;
        int unsigned e, k;
        send(CNT_W'(6), ok);
        enable_i = 1'b1;
        k = 0;
        while (!pulse_o && k < 50) begin
            step();
            k++;
        end
        send(CNT_W'(9), ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_send: ready got 0 want 1"); end
        reset_count = 1'b0;
        step();
        n_checks++; if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse: got %b want 0", pulse_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
        n_checks++; if (cnt_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", cnt_ready_o); end
        n_checks++; if (frame_start_o !== 1'b0 || frame_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobes: got %b%b want 00", frame_start_o, frame_done_o); end
        step();
        reset_count = 1'b1;
        exp_q.push_back(0);
        wait_frame(400, f, ok);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f.n !== e) begin n_fail++; $display("FAIL rst_mid_cleared: got %0d pulses want %0d", f.n, e); end
    endtask

    task automatic test_large();
        bit ok;
        frame_t f;
        int unsigned e;
`ifdef LMT01_TEMP_IN_EN
        send(CNT_W'(12'hF19), ok);
`else
        send(CNT_W'(1200), ok);
`endif
        exp_q.push_back(1200);
        enable_i = 1'b1;
        wait_frame(12000, f, ok);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f.n !== e) begin n_fail++; $display("FAIL large_count: got %0d want %0d", f.n, e); end
`ifdef LMT01_TEMP_IN_EN
        n_checks++; if (int'(f.n * 256 / 4096) - 50 !== 25) begin n_fail++; $display("FAIL large_temp_rt: got %0d want 25", int'(f.n * 256 / 4096) - 50); end
        send(CNT_W'(230), ok);
`else
        send(CNT_W'(4095), ok);
`endif
        exp_q.push_back(4095);
        enable_i = 1'b1;
        wait_frame(40000, f, ok);
        enable_i = 1'b0;
        step();
        e = exp_q.pop_front();
        n_checks++; if (f.n !== e) begin n_fail++; $display("FAIL max_count: got %0d want %0d", f.n, e); end
        n_checks++; if (f.bad !== 1'b0) begin n_fail++; $display("FAIL max_width: got bad=%0d want 0", f.bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_pending_hold();
        test_overrun();
        test_enable_drop();
        test_reset_mid();
        test_large();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
